// File: rtl/vram_text_writer_if.sv
// Character stream and VRAM port bundle for the text-mode writer.
//  char_valid/char_data/char_ready : byte stream from CPU/console
//  vram_we/vram_waddr/vram_wdata   : VRAM write port
//  vram_raddr/vram_rdata           : VRAM read port (rdata valid 1 cycle after raddr)
// master = byte source + VRAM side, slave = vram_text_writer.
interface vram_text_writer_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_waddr;
  logic [DATA_W-1:0] vram_wdata;
  logic [ADDR_W-1:0] vram_raddr;
  logic [DATA_W-1:0] vram_rdata;

  modport master (
    output char_valid, char_data, vram_rdata,
    input  char_ready, vram_we, vram_waddr, vram_wdata, vram_raddr
  );

  modport slave (
    input  char_valid, char_data, vram_rdata,
    output char_ready, vram_we, vram_waddr, vram_wdata, vram_raddr
  );
endinterface

// File: rtl/vram_text_writer.sv
// Text-mode VRAM writer: converts a byte stream into character-cell writes,
// tracks the cursor, and handles CR, LF, BS, form-feed clear, wrap and scroll.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  bus (slave)         byte handshake + VRAM read/write ports
//  cursor_col/row      registered cursor position
//  busy                high whenever not IDLE
module vram_text_writer #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  vram_text_writer_if.slave    bus,
  output logic [6:0]           cursor_col,
  output logic [4:0]           cursor_row,
  output logic                 busy
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned COPY_N = (ROWS - 1) * COLS;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUT      = 3'd1;
  localparam logic [2:0] S_SCROLL   = 3'd2;
  localparam logic [2:0] S_CLR_LINE = 3'd3;
  localparam logic [2:0] S_CLR_ALL  = 3'd4;

  localparam logic [7:0]        CH_BS = 8'h08;
  localparam logic [7:0]        CH_LF = 8'h0A;
  localparam logic [7:0]        CH_FF = 8'h0C;
  localparam logic [7:0]        CH_CR = 8'h0D;
  localparam logic [DATA_W-1:0] SPACE = DATA_W'(8'h20);

  logic [2:0]        state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [7:0]        ch_q, ch_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              copy_q, copy_d;
  logic              ready_q, busy_q;
  logic [ADDR_W-1:0] cell_addr;

  assign cell_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  assign bus.char_ready = ready_q;
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = waddr_q;
  assign bus.vram_raddr = raddr_q;
  // Scroll copy forwards the read port straight to the write port so the
  // write lags the read address by exactly one cycle.
  assign bus.vram_wdata = copy_q ? bus.vram_rdata : wdata_q;
  assign cursor_col     = col_q;
  assign cursor_row     = row_q;
  assign busy           = busy_q;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    copy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.char_valid) begin
          ch_d = bus.char_data;
          case (bus.char_data)
            CH_CR: col_d = 7'd0;
            CH_LF: begin
              if (row_q < 5'(ROWS - 1)) begin
                col_d = 7'd0;
                row_d = row_q + 5'd1;
              end else begin
                state_d = S_SCROLL;
                cnt_d   = '0;
                raddr_d = ADDR_W'(COLS);
              end
            end
            CH_BS: begin
              if (col_q != 7'd0) begin
                state_d = S_PUT;
                we_d    = 1'b1;
                waddr_d = cell_addr - ADDR_W'(1);
                wdata_d = SPACE;
              end
            end
            CH_FF: begin
              state_d = S_CLR_ALL;
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = SPACE;
              cnt_d   = '0;
            end
            default: begin
              state_d = S_PUT;
              we_d    = 1'b1;
              waddr_d = cell_addr;
              wdata_d = DATA_W'(bus.char_data);
            end
          endcase
        end
      end

      // Write was issued on entry; update the cursor as the write completes.
      S_PUT: begin
        state_d = S_IDLE;
        if (ch_q == CH_BS) begin
          col_d = col_q - 7'd1;
        end else if (col_q < 7'(COLS - 1)) begin
          col_d = col_q + 7'd1;
        end else if (row_q < 5'(ROWS - 1)) begin
          col_d = 7'd0;
          row_d = row_q + 5'd1;
        end else begin
          state_d = S_SCROLL;
          cnt_d   = '0;
          raddr_d = ADDR_W'(COLS);
        end
      end

      // cnt counts scroll cycles; cycle k+1 writes cell k from the read of k+COLS.
      S_SCROLL: begin
        if (cnt_q < ADDR_W'(COPY_N)) begin
          we_d    = 1'b1;
          copy_d  = 1'b1;
          waddr_d = cnt_q;
          cnt_d   = cnt_q + ADDR_W'(1);
          raddr_d = (cnt_q + ADDR_W'(1) < ADDR_W'(COPY_N))
                    ? cnt_q + ADDR_W'(COLS + 1) : '0;
        end else begin
          state_d = S_CLR_LINE;
          we_d    = 1'b1;
          waddr_d = ADDR_W'(COPY_N);
          wdata_d = SPACE;
          cnt_d   = '0;
          raddr_d = '0;
        end
      end

      S_CLR_LINE: begin
        if (cnt_q < ADDR_W'(COLS - 1)) begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          cnt_d   = cnt_q + ADDR_W'(1);
        end else begin
          state_d = S_IDLE;
          row_d   = 5'(ROWS - 1);
          col_d   = 7'd0;
        end
      end

      S_CLR_ALL: begin
        if (cnt_q < ADDR_W'(CELLS - 1)) begin
          we_d    = 1'b1;
          waddr_d = waddr_q + ADDR_W'(1);
          cnt_d   = cnt_q + ADDR_W'(1);
        end else begin
          state_d = S_IDLE;
          row_d   = 5'd0;
          col_d   = 7'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
      ch_q    <= 8'd0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      copy_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      raddr_q <= raddr_d;
      copy_q  <= copy_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_vram_text_writer.sv
// Scoreboard bench for vram_text_writer: a screen-level model predicts VRAM
// writes, busy duration and cursor per byte; a monitor checks each write.
module tb_vram_text_writer;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 12;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  vram_text_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bench-side VRAM: synchronous write, registered read.
  logic [DATA_W-1:0] vram [CELLS];
  logic [DATA_W-1:0] rdata_q = '0;
  assign bus.vram_rdata = rdata_q;
  always @(posedge clk) begin
    if (bus.vram_we && int'(bus.vram_waddr) < CELLS) vram[int'(bus.vram_waddr)] <= bus.vram_wdata;
    if (int'(bus.vram_raddr) < CELLS) rdata_q <= vram[int'(bus.vram_raddr)];
  end

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  // Reference screen model
  int ref_mem [CELLS];
  int m_row = 0;
  int m_col = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void push(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    ref_mem[a] = d;
  endfunction

  function automatic void model_scroll();
    for (int i = 0; i < (ROWS - 1) * COLS; i++) push(i, ref_mem[i + COLS]);
    for (int i = (ROWS - 1) * COLS; i < CELLS; i++) push(i, 'h20);
    m_row = ROWS - 1;
    m_col = 0;
  endfunction

  // Returns the number of cycles the writer should stay not-ready.
  function automatic int model_byte(input int b);
    int bc = 0;
    case (b)
      'h0D: m_col = 0;
      'h0A: begin
        if (m_row < ROWS - 1) begin
          m_col = 0;
          m_row++;
        end else begin
          model_scroll();
          bc = (ROWS - 1) * COLS + 1 + COLS;
        end
      end
      'h08: begin
        if (m_col > 0) begin
          m_col--;
          push(m_row * COLS + m_col, 'h20);
          bc = 1;
        end
      end
      'h0C: begin
        for (int a = 0; a < CELLS; a++) push(a, 'h20);
        m_row = 0;
        m_col = 0;
        bc = CELLS;
      end
      default: begin
        push(m_row * COLS + m_col, b);
        bc = 1;
        m_col++;
        if (m_col == COLS) begin
          m_col = 0;
          if (m_row < ROWS - 1) m_row++;
          else begin
            model_scroll();
            bc += (ROWS - 1) * COLS + 1 + COLS;
          end
        end
      end
    endcase
    return bc;
  endfunction

  // Monitor: every VRAM write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst && bus.vram_we) begin
      check("ready_low_during_write", int'(bus.char_ready), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(bus.vram_waddr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", int'(bus.vram_waddr), e.addr);
        check("write_data", int'(bus.vram_wdata), e.data);
      end
    end
  end

  task automatic send(input int b);
    int exp_bc;
    int n;
    exp_bc = model_byte(b);
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'(b);
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'($urandom);
    n = 0;
    while (n <= 6000) begin
      @(negedge clk);
      if (bus.char_ready) break;
      n++;
    end
    check("busy_cycles", n, exp_bc);
    check("cursor_col", int'(cursor_col), m_col);
    check("cursor_row", int'(cursor_row), m_row);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic goto_row(input int r);
    send('h0D);
    while (m_row != r) send('h0A);
  endtask

  task automatic reset_mid_scroll();
    goto_row(ROWS - 1);
    void'(model_byte('h0A));
    @(negedge clk);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0A;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("scroll_we_before_rst", int'(bus.vram_we), 1);
    rst = 1'b1;
    #1;
    check("we_drop_on_rst", int'(bus.vram_we), 0);
    @(negedge clk);
    check("rst_ready", int'(bus.char_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_col", int'(cursor_col), 0);
    check("rst_row", int'(cursor_row), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(bus.char_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_we", int'(bus.vram_we), 0);
    check("reset_waddr", int'(bus.vram_waddr), 0);
    check("reset_col", int'(cursor_col), 0);
    check("reset_row", int'(cursor_row), 0);
    rst = 1'b0;
    @(negedge clk);

    send('h41);                       // 'A' at addr 0
    send('h0C);                       // clear, also defines VRAM contents
    for (int i = 0; i < COLS + 1; i++) send($urandom_range(32, 126));
    goto_row(ROWS - 1);
    for (int i = 0; i < 10; i++) send($urandom_range(32, 255));
    send('h0A);                       // scroll from (29,10)
    send('h0C);
    goto_row(3);
    for (int i = 0; i < 5; i++) send($urandom_range(32, 126));
    send('h08);                       // space at 244, cursor (3,4)
    send('h0D);
    send('h08);                       // col 0: no write
    goto_row(ROWS - 1);
    for (int i = 0; i < COLS; i++) send($urandom_range(32, 126)); // wrap at last cell

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      send($urandom_range(32, 255));
      else if (r < 88) send('h0A);
      else if (r < 93) send('h0D);
      else if (r < 99) send('h08);
      else             send('h0C);
    end

    reset_mid_scroll();
    send('h0C);
    send('h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
